pump_sequencer: RTL and testbench

PUMP_SEQUENCER -- requirements
Module: pump_sequencer

---
 rtl/pump_sequencer_if.sv | 27 ++
 rtl/pump_sequencer.sv | 152 +++++++++++++++
 tb/tb_pump_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pump_sequencer_if.sv
// Signal bundle between the pump sequencer and its controller: operator
// inputs and level measurement toward the sequencer, pump drive and status back.
interface pump_sequencer_if;
    logic        enable;
    logic [7:0]  level;
    logic        level_valid;
    logic [7:0]  high_threshold;
    logic [7:0]  low_threshold;
    logic        fault_clear;
    logic        pump_on;
    logic        alarm_timeout;
    logic        alarm_overflow;
    logic [1:0]  state;
    logic [15:0] start_count;

    // Controller side: drives commands and measurements, observes status.
    modport master (
        output enable, level, level_valid, high_threshold, low_threshold, fault_clear,
        input  pump_on, alarm_timeout, alarm_overflow, state, start_count
    );

    // Sequencer side: consumes commands and measurements, drives status.
    modport slave (
        input  enable, level, level_valid, high_threshold, low_threshold, fault_clear,
        output pump_on, alarm_timeout, alarm_overflow, state, start_count
    );
endinterface

// File: rtl/pump_sequencer.sv
// Tank fill pump sequencer.
// OFF -> FILL when the level drops to the low threshold, FILL -> DWELL when
// the high threshold is reached or filling is no longer permitted, DWELL holds
// the pump off for MIN_OFF cycles before returning to OFF. A FILL lasting
// FILL_TIMEOUT cycles, or any out-of-range level, latches FAULT until cleared.
// All outputs are registered; the pump drive is a decode of the next state.
module pump_sequencer #(
    parameter logic [31:0] FILL_TIMEOUT = 32'd500_000_000,
    parameter logic [31:0] MIN_OFF      = 32'd100_000_000
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    pump_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Largest physically meaningful level reading, in percent.
    localparam logic [7:0] LEVEL_MAX = 8'd100;

    // Terminal timer values: the transition fires on the edge that ends
    // the cycle in which the timer holds this value.
    localparam logic [31:0] FILL_LAST  = FILL_TIMEOUT - 32'd1;
    localparam logic [31:0] DWELL_LAST = MIN_OFF - 32'd1;

    logic [1:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        pump_on_q, pump_on_d;
    logic        alarm_timeout_q, alarm_timeout_d;
    logic        alarm_overflow_q, alarm_overflow_d;
    logic [15:0] start_count_q, start_count_d;

    logic thresholds_ok;
    logic level_overflow;
    logic high_reached;
    logic start_request;
    logic stop_request;
    logic fill_expired;
    logic dwell_expired;

    // Start counter holds at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // Condition decode, recomputed every cycle from the live inputs so a
    // threshold change during FILL affects the very next stop decision.
    always_comb begin
        thresholds_ok  = (bus.low_threshold < bus.high_threshold) &&
                         (bus.high_threshold <= LEVEL_MAX);
        level_overflow = bus.level_valid && (bus.level > LEVEL_MAX);
        high_reached   = bus.level_valid && (bus.level >= bus.high_threshold);
        start_request  = bus.enable && bus.level_valid && thresholds_ok &&
                         (bus.level <= bus.low_threshold);
        stop_request   = high_reached || !bus.enable || !thresholds_ok;
        fill_expired   = (timer_q == FILL_LAST);
        dwell_expired  = (timer_q == DWELL_LAST);
    end

    // Next-state logic; overflow pre-empts every state, including a
    // coincident fault_clear, so the alarm cannot be cleared while the
    // bad reading persists.
    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        alarm_timeout_d  = alarm_timeout_q;
        alarm_overflow_d = alarm_overflow_q;
        start_count_d    = start_count_q;

        if (level_overflow) begin
            state_d          = ST_FAULT;
            alarm_overflow_d = 1'b1;
            timer_d          = 32'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    timer_d = 32'd0;
                    if (start_request) begin
                        state_d       = ST_FILL;
                        start_count_d = sat_inc16(start_count_q);
                    end
                end
                ST_FILL: begin
                    if (fill_expired) begin
                        // Timeout outranks a stop condition seen in the same cycle.
                        state_d         = ST_FAULT;
                        alarm_timeout_d = 1'b1;
                        timer_d         = 32'd0;
                    end else if (stop_request) begin
                        state_d = ST_DWELL;
                        timer_d = 32'd0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                ST_DWELL: begin
                    // Enable and level are deliberately ignored: the pump
                    // must rest for the full off period after every stop.
                    if (dwell_expired) begin
                        state_d = ST_OFF;
                        timer_d = 32'd0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                default: begin
                    timer_d = 32'd0;
                    if (bus.fault_clear) begin
                        // Leave through DWELL so a restart still honours MIN_OFF.
                        state_d          = ST_DWELL;
                        alarm_timeout_d  = 1'b0;
                        alarm_overflow_d = 1'b0;
                    end
                end
            endcase
        end

        pump_on_d = (state_d == ST_FILL);
    end

    // State and output registers; reset forces the pump off without waiting for a clock.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q          <= ST_OFF;
            timer_q          <= 32'd0;
            pump_on_q        <= 1'b0;
            alarm_timeout_q  <= 1'b0;
            alarm_overflow_q <= 1'b0;
            start_count_q    <= 16'd0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            pump_on_q        <= pump_on_d;
            alarm_timeout_q  <= alarm_timeout_d;
            alarm_overflow_q <= alarm_overflow_d;
            start_count_q    <= start_count_d;
        end
    end

    assign bus.pump_on        = pump_on_q;
    assign bus.alarm_timeout  = alarm_timeout_q;
    assign bus.alarm_overflow = alarm_overflow_q;
    assign bus.state          = state_q;
    assign bus.start_count    = start_count_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed bench for pump_sequencer with FILL_TIMEOUT=20, MIN_OFF=5.
// Stimulus queues hand-computed expected outputs tagged with the clock edge
// after which they must hold; a monitor compares them as those edges pass.
module tb_pump_sequencer;

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic clk_100MHz;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    event chk_ev;

    typedef struct {
        int          tgt;      // edge index to check after; -1 = check immediately
        string       name;
        logic [1:0]  st;
        logic        pump;
        logic        at;
        logic        ao;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];

    pump_sequencer_if bus ();

    pump_sequencer #(
        .FILL_TIMEOUT (32'd20),
        .MIN_OFF      (32'd5)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic expect_at(input int k, input string nm, input logic [1:0] st,
                             input logic p, input logic at, input logic ao,
                             input logic [15:0] sc);
        exp_t e;
        e.tgt = cyc + k; e.name = nm; e.st = st; e.pump = p;
        e.at = at; e.ao = ao; e.sc = sc;
        q.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic [1:0] st, input logic p,
                             input logic at, input logic ao, input logic [15:0] sc);
        exp_t e;
        e.tgt = -1; e.name = nm; e.st = st; e.pump = p;
        e.at = at; e.ao = ao; e.sc = sc;
        q.push_back(e);
        -> chk_ev;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    // Monitor: compares every due expectation against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk_100MHz or chk_ev);
            while (q.size() > 0 && (q[0].tgt == -1 || q[0].tgt <= cyc)) begin
                exp_t e;
                e = q.pop_front();
                n_checks++;
                if (e.tgt != -1 && e.tgt < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check missed its edge (due %0d, now %0d)", e.name, e.tgt, cyc);
                end else if (bus.state !== e.st || bus.pump_on !== e.pump ||
                             bus.alarm_timeout !== e.at || bus.alarm_overflow !== e.ao ||
                             bus.start_count !== e.sc) begin
                    n_fail++;
                    $display("FAIL %s: got state=%0d pump=%b at=%b ao=%b cnt=%0d, expected state=%0d pump=%b at=%b ao=%b cnt=%0d",
                             e.name, bus.state, bus.pump_on, bus.alarm_timeout, bus.alarm_overflow,
                             bus.start_count, e.st, e.pump, e.at, e.ao, e.sc);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.level = 8'd50; bus.level_valid = 1'b0;
        bus.low_threshold = 8'd20; bus.high_threshold = 8'd80; bus.fault_clear = 1'b0;
        #2;
        check_now("reset_state", S_OFF, 0, 0, 0, 16'd0);
        @(posedge clk_100MHz); #1;
        reset = 1'b0;

        // Basic fill cycle and dwell
        bus.enable = 1'b1; bus.level_valid = 1'b1; bus.level = 8'd15;
        expect_at(1, "t1_fill", S_FILL, 1, 0, 0, 16'd1); ticks(1);
        bus.level = 8'd80;
        expect_at(1, "t1_dwell", S_DWELL, 0, 0, 0, 16'd1); ticks(1);
        bus.level = 8'd50;
        expect_at(4, "t1_dwell_hold", S_DWELL, 0, 0, 0, 16'd1);
        expect_at(5, "t1_off", S_OFF, 0, 0, 0, 16'd1); ticks(5);

        // Fill timeout, then clear
        bus.level = 8'd15;
        expect_at(1, "t2_fill", S_FILL, 1, 0, 0, 16'd2); ticks(1);
        bus.level = 8'd50;
        expect_at(19, "t2_fill_last", S_FILL, 1, 0, 0, 16'd2);
        expect_at(20, "t2_timeout", S_FAULT, 0, 1, 0, 16'd2); ticks(20);
        bus.fault_clear = 1'b1;
        expect_at(1, "t2_clear", S_DWELL, 0, 0, 0, 16'd2); ticks(1);
        bus.fault_clear = 1'b0;
        expect_at(5, "t2_off", S_OFF, 0, 0, 0, 16'd2); ticks(5);

        // Overflow from OFF, clear blocked while overflow persists
        bus.level = 8'd101;
        expect_at(1, "t3_overflow", S_FAULT, 0, 0, 1, 16'd2); ticks(1);
        bus.fault_clear = 1'b1;
        expect_at(1, "t3_clear_blocked", S_FAULT, 0, 0, 1, 16'd2); ticks(1);
        bus.level = 8'd50;
        expect_at(1, "t3_clear", S_DWELL, 0, 0, 0, 16'd2); ticks(1);
        bus.fault_clear = 1'b0;
        expect_at(5, "t3_off", S_OFF, 0, 0, 0, 16'd2); ticks(5);
        bus.fault_clear = 1'b1;
        expect_at(1, "clear_in_off", S_OFF, 0, 0, 0, 16'd2); ticks(1);
        bus.fault_clear = 1'b0;

        // Invalid thresholds: no start, and forced stop during FILL
        bus.low_threshold = 8'd80; bus.high_threshold = 8'd20; bus.level = 8'd10;
        expect_at(1, "t4_inv_off1", S_OFF, 0, 0, 0, 16'd2);
        expect_at(2, "t4_inv_off2", S_OFF, 0, 0, 0, 16'd2); ticks(2);
        bus.low_threshold = 8'd20; bus.high_threshold = 8'd80;
        expect_at(1, "t4_fill", S_FILL, 1, 0, 0, 16'd3); ticks(1);
        bus.low_threshold = 8'd80; bus.high_threshold = 8'd20;
        expect_at(1, "t4_inv_stop", S_DWELL, 0, 0, 0, 16'd3); ticks(1);
        bus.low_threshold = 8'd20; bus.high_threshold = 8'd80; bus.level = 8'd50;
        expect_at(5, "t4_off", S_OFF, 0, 0, 0, 16'd3); ticks(5);

        // Timeout beats high-reached in the same cycle
        bus.level = 8'd15;
        expect_at(1, "t5_fill", S_FILL, 1, 0, 0, 16'd4); ticks(1);
        bus.level = 8'd50;
        expect_at(19, "t5_fill_last", S_FILL, 1, 0, 0, 16'd4); ticks(19);
        bus.level = 8'd85;
        expect_at(1, "t5_timeout_wins", S_FAULT, 0, 1, 0, 16'd4); ticks(1);
        bus.level = 8'd50; bus.fault_clear = 1'b1;
        expect_at(1, "t5_clear", S_DWELL, 0, 0, 0, 16'd4); ticks(1);
        bus.fault_clear = 1'b0;
        expect_at(5, "t5_off", S_OFF, 0, 0, 0, 16'd4); ticks(5);

        // Threshold lowered mid-FILL stops immediately
        bus.level = 8'd15;
        expect_at(1, "t6_fill", S_FILL, 1, 0, 0, 16'd5); ticks(1);
        bus.level = 8'd50;
        expect_at(1, "t6_fill_hold", S_FILL, 1, 0, 0, 16'd5); ticks(1);
        bus.high_threshold = 8'd50;
        expect_at(1, "t6_new_high", S_DWELL, 0, 0, 0, 16'd5); ticks(1);
        bus.high_threshold = 8'd80;
        expect_at(5, "t6_off", S_OFF, 0, 0, 0, 16'd5); ticks(5);

        // Enable drop during FILL
        bus.level = 8'd15;
        expect_at(1, "t7_fill", S_FILL, 1, 0, 0, 16'd6); ticks(1);
        bus.level = 8'd50; bus.enable = 1'b0;
        expect_at(1, "t7_enable_drop", S_DWELL, 0, 0, 0, 16'd6); ticks(1);
        bus.enable = 1'b1;
        expect_at(5, "t7_off", S_OFF, 0, 0, 0, 16'd6); ticks(5);

        // Overflow during FILL
        bus.level = 8'd15;
        expect_at(1, "t8_fill", S_FILL, 1, 0, 0, 16'd7); ticks(1);
        bus.level = 8'd120;
        expect_at(1, "t8_overflow", S_FAULT, 0, 0, 1, 16'd7); ticks(1);
        bus.level = 8'd50; bus.fault_clear = 1'b1;
        expect_at(1, "t8_clear", S_DWELL, 0, 0, 0, 16'd7); ticks(1);
        bus.fault_clear = 1'b0;
        expect_at(5, "t8_off", S_OFF, 0, 0, 0, 16'd7); ticks(5);

        // level_valid low ignores the level entirely
        bus.level = 8'd15;
        expect_at(1, "t9_fill", S_FILL, 1, 0, 0, 16'd8); ticks(1);
        bus.level_valid = 1'b0; bus.level = 8'd90;
        expect_at(1, "t9_invalid_hi", S_FILL, 1, 0, 0, 16'd8);
        expect_at(2, "t9_invalid_ovf", S_FILL, 1, 0, 0, 16'd8); ticks(1);
        bus.level = 8'd200; ticks(1);
        bus.level_valid = 1'b1; bus.level = 8'd90;
        expect_at(1, "t9_valid_hi", S_DWELL, 0, 0, 0, 16'd8); ticks(1);
        bus.level = 8'd50;
        expect_at(5, "t9_off", S_OFF, 0, 0, 0, 16'd8); ticks(5);

        // Asynchronous reset in the middle of FILL
        bus.level = 8'd15;
        expect_at(1, "t10_fill", S_FILL, 1, 0, 0, 16'd9); ticks(1);
        bus.level = 8'd50; ticks(2);
        #2;
        reset = 1'b1;
        #1;
        check_now("t10_async_reset", S_OFF, 0, 0, 0, 16'd0);
        @(posedge clk_100MHz); #1;
        reset = 1'b0;
        bus.level = 8'd15;
        expect_at(1, "t10_restart", S_FILL, 1, 0, 0, 16'd1); ticks(1);
        bus.level = 8'd50; bus.enable = 1'b0;
        expect_at(1, "t10_stop", S_DWELL, 0, 0, 0, 16'd1); ticks(1);

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk_100MHz);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked (due edge %0d)", e.name, e.tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
